// File: rtl/ofm_packer.sv
// rtl/ofm_packer.sv - packs IN_WIDTH-bit beats into contiguous OUT_WIDTH-bit words with flush support.
// Optional feature: define OFM_PACKER_KEEP_EN to add the registered out_keep byte-valid output.
module ofm_packer #(
    parameter int IN_WIDTH  = 56,
    parameter int OUT_WIDTH = 512
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [IN_WIDTH-1:0]    in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   flush,
    input  logic                   stall,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
`ifdef OFM_PACKER_KEEP_EN
    output logic [OUT_WIDTH/8-1:0] out_keep,
`endif
    output logic [15:0]            word_cnt
);

    localparam int IN_BYTES  = IN_WIDTH / 8;
    localparam int OUT_BYTES = OUT_WIDTH / 8;
    localparam int FW        = $clog2(OUT_BYTES);
    localparam int PW        = FW + 1;

    typedef enum logic [1:0] {
        ST_ACCUM,
        ST_HOLD,
        ST_FLUSH_PEND,
        ST_FLUSH_LAST
    } state_t;

    state_t                 state_q, state_d;
    logic [OUT_WIDTH-1:0]   acc_q, acc_d;
    logic [FW-1:0]          fill_q, fill_d;
    logic [OUT_WIDTH-1:0]   out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;
    logic [15:0]            word_cnt_q, word_cnt_d;
`ifdef OFM_PACKER_KEEP_EN
    logic [OUT_BYTES-1:0]   keep_q, keep_d;
`endif

    logic                   flush_pending;
    logic                   beat_hs;
    logic                   flush_hs;
    logic                   out_accept;
    logic [OUT_WIDTH-1:0]   cur_word;
    logic [OUT_WIDTH-1:0]   spill_word;
    logic [PW-1:0]          fill_sum;
    logic                   completes;
    logic [FW-1:0]          new_fill;
    logic [FW-1:0]          post_fill;

`ifdef OFM_PACKER_KEEP_EN
    function automatic logic [OUT_BYTES-1:0] low_mask(input logic [FW-1:0] n);
        logic [OUT_BYTES-1:0] m;
        m = '0;
        for (int b = 0; b < OUT_BYTES; b++) begin
            m[b] = (b < int'(n));
        end
        return m;
    endfunction
`endif

    assign flush_pending = (state_q == ST_FLUSH_PEND) || (state_q == ST_FLUSH_LAST);
    assign in_ready      = !stall && !flush_pending && (!out_valid_q || out_ready);
    assign beat_hs       = in_valid && in_ready;
    assign flush_hs      = flush && in_ready;
    assign out_accept    = out_valid_q && out_ready;

    // Bytes landing past the word end wrap into the start of the next word.
    always_comb begin
        cur_word   = acc_q;
        spill_word = '0;
        for (int i = 0; i < IN_BYTES; i++) begin
            if (int'(fill_q) + i < OUT_BYTES) begin
                cur_word[(int'(fill_q) + i) * 8 +: 8] = in_data[i * 8 +: 8];
            end else begin
                spill_word[(int'(fill_q) + i - OUT_BYTES) * 8 +: 8] = in_data[i * 8 +: 8];
            end
        end
    end

    always_comb begin
        fill_sum  = {1'b0, fill_q} + PW'(IN_BYTES);
        completes = (fill_sum >= PW'(OUT_BYTES));
        new_fill  = completes ? FW'(fill_sum - PW'(OUT_BYTES)) : FW'(fill_sum);
        post_fill = beat_hs ? new_fill : fill_q;
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        fill_d      = fill_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        word_cnt_d  = word_cnt_q + {15'd0, out_accept};
`ifdef OFM_PACKER_KEEP_EN
        keep_d      = keep_q;
`endif
        if (out_accept) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        case (state_q)
            ST_FLUSH_PEND: begin
                // Leftover bytes already sit zero-padded in the accumulator.
                if (out_accept) begin
                    out_data_d  = acc_q;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b1;
`ifdef OFM_PACKER_KEEP_EN
                    keep_d      = low_mask(fill_q);
`endif
                    acc_d       = '0;
                    fill_d      = '0;
                    state_d     = ST_FLUSH_LAST;
                end
            end
            ST_FLUSH_LAST: begin
                if (out_accept) begin
                    state_d = ST_ACCUM;
                end
            end
            default: begin
                if (beat_hs) begin
                    fill_d = new_fill;
                    if (completes) begin
                        acc_d       = spill_word;
                        out_data_d  = cur_word;
                        out_valid_d = 1'b1;
                        out_last_d  = 1'b0;
`ifdef OFM_PACKER_KEEP_EN
                        keep_d      = '1;
`endif
                    end else begin
                        acc_d = cur_word;
                    end
                end

                if (flush_hs) begin
                    if (beat_hs && completes) begin
                        if (new_fill == '0) begin
                            out_last_d = 1'b1;
                        end
                    end else if (post_fill != '0) begin
                        out_data_d  = beat_hs ? cur_word : acc_q;
                        out_valid_d = 1'b1;
                        out_last_d  = 1'b1;
`ifdef OFM_PACKER_KEEP_EN
                        keep_d      = low_mask(post_fill);
`endif
                        acc_d       = '0;
                        fill_d      = '0;
                    end
                end

                if (flush_hs && beat_hs && completes && (new_fill != '0)) begin
                    state_d = ST_FLUSH_PEND;
                end else begin
                    state_d = out_valid_d ? ST_HOLD : ST_ACCUM;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            fill_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            word_cnt_q  <= '0;
`ifdef OFM_PACKER_KEEP_EN
            keep_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            word_cnt_q  <= word_cnt_d;
`ifdef OFM_PACKER_KEEP_EN
            keep_q      <= keep_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign word_cnt  = word_cnt_q;
`ifdef OFM_PACKER_KEEP_EN
    assign out_keep  = keep_q;
`endif

endmodule

// File: tb/tb_ofm_packer.sv
// tb/tb_ofm_packer.sv - directed self-checking bench for ofm_packer.
module tb_ofm_packer;

    localparam int IW = 56;
    localparam int OW = 512;
    localparam int IB = 7;
    localparam int OB = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [IW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          flush;
    logic          stall;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [15:0]   word_cnt;
`ifdef OFM_PACKER_KEEP_EN
    logic [OB-1:0] out_keep;
`endif

    int checks   = 0;
    int failures = 0;
    int gb       = 0;

    logic [OW-1:0] cap_data[$];
    logic          cap_last[$];
    logic [OB-1:0] cap_keep[$];

    always #5 clk = ~clk;

    ofm_packer #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .stall     (stall),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
`ifdef OFM_PACKER_KEEP_EN
        .out_keep  (out_keep),
`endif
        .word_cnt  (word_cnt)
    );

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            cap_data.push_back(out_data);
            cap_last.push_back(out_last);
`ifdef OFM_PACKER_KEEP_EN
            cap_keep.push_back(out_keep);
`else
            cap_keep.push_back('0);
`endif
        end
    end

    function automatic logic [IW-1:0] make_beat(input int g);
        logic [IW-1:0] b;
        b = '0;
        for (int i = 0; i < IB; i++) b[i*8 +: 8] = 8'((g + i) % 256);
        return b;
    endfunction

    function automatic logic [OW-1:0] exp_word(input int start, input int n);
        logic [OW-1:0] w;
        w = '0;
        for (int k = 0; k < n; k++) w[k*8 +: 8] = 8'((start + k) % 256);
        return w;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; stall = 1'b0;
        out_ready = 1'b1; in_data = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cap_data.delete(); cap_last.delete(); cap_keep.delete();
        gb = 0;
    endtask

    task automatic do_beat(input logic v, input logic f);
        int n;
        in_valid = v; flush = f; in_data = make_beat(gb);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) begin
            checks++; failures++;
            $display("FAIL beat_timeout in_ready=%0b required=1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        if (v) gb += IB;
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 || word_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_outputs valid=%0b last=%0b cnt=%0d required 0/0/0", out_valid, out_last, word_cnt);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%0b required=1", in_ready);
        end
    endtask

    task automatic test_stream();
        apply_reset();
        do_beat(1'b0, 1'b1);
        settle();
        checks++;
        if (cap_data.size() != 0) begin
            failures++;
            $display("FAIL flush_empty words=%0d required=0", cap_data.size());
        end
        for (int b = 0; b < 64; b++) do_beat(1'b1, 1'b0);
        settle();
        checks++;
        if (cap_data.size() != 7) begin
            failures++;
            $display("FAIL stream_count words=%0d required=7", cap_data.size());
        end
        for (int k = 0; k < 7 && k < cap_data.size(); k++) begin
            checks++;
            if (cap_data[k] !== exp_word(k * 64, 64) || cap_last[k] !== 1'b0) begin
                failures++;
                $display("FAIL stream_word%0d last=%0b data=%h required=%h", k, cap_last[k], cap_data[k], exp_word(k * 64, 64));
            end
        end
        checks++;
        if (word_cnt !== 16'd7) begin
            failures++;
            $display("FAIL stream_word_cnt got=%0d required=7", word_cnt);
        end
        do_beat(1'b0, 1'b1);
        settle();
        checks++;
        if (cap_data.size() != 7) begin
            failures++;
            $display("FAIL stream_fill_zero words=%0d required=7", cap_data.size());
        end
    endtask

    task automatic test_flush_alone();
        apply_reset();
        for (int b = 0; b < 10; b++) do_beat(1'b1, 1'b0);
        do_beat(1'b0, 1'b1);
        settle();
        checks++;
        if (cap_data.size() != 2) begin
            failures++;
            $display("FAIL flush_alone_count words=%0d required=2", cap_data.size());
        end else begin
            checks++;
            if (cap_data[0] !== exp_word(0, 64) || cap_last[0] !== 1'b0) begin
                failures++;
                $display("FAIL flush_alone_w0 last=%0b data=%h", cap_last[0], cap_data[0]);
            end
            checks++;
            if (cap_data[1] !== exp_word(64, 6) || cap_last[1] !== 1'b1) begin
                failures++;
                $display("FAIL flush_alone_w1 last=%0b data=%h required=%h", cap_last[1], cap_data[1], exp_word(64, 6));
            end
`ifdef OFM_PACKER_KEEP_EN
            checks++;
            if (cap_keep[1] !== 64'h3F || cap_keep[0] !== '1) begin
                failures++;
                $display("FAIL flush_alone_keep got=%h/%h required=ff..ff/3f", cap_keep[0], cap_keep[1]);
            end
`endif
        end
        checks++;
        if (word_cnt !== 16'd2) begin
            failures++;
            $display("FAIL flush_alone_cnt got=%0d required=2", word_cnt);
        end
    endtask

    task automatic test_flush_with_beat();
        apply_reset();
        for (int b = 0; b < 9; b++) do_beat(1'b1, 1'b0);
        do_beat(1'b1, 1'b1);
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_last !== 1'b0) begin
                failures++;
                $display("FAIL fwb_hold in_ready=%0b valid=%0b last=%0b required 0/1/0", in_ready, out_valid, out_last);
            end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_last !== 1'b0) begin
            failures++;
            $display("FAIL fwb_first in_ready=%0b last=%0b required 0/0", in_ready, out_last);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_last !== 1'b1) begin
            failures++;
            $display("FAIL fwb_leftover in_ready=%0b valid=%0b last=%0b required 0/1/1", in_ready, out_valid, out_last);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL fwb_release in_ready=%0b required=1", in_ready);
        end
        settle();
        checks++;
        if (cap_data.size() != 2) begin
            failures++;
            $display("FAIL fwb_count words=%0d required=2", cap_data.size());
        end else begin
            checks++;
            if (cap_data[0] !== exp_word(0, 64) || cap_last[0] !== 1'b0 ||
                cap_data[1] !== exp_word(64, 6) || cap_last[1] !== 1'b1) begin
                failures++;
                $display("FAIL fwb_words last0=%0b last1=%0b data1=%h required=%h", cap_last[0], cap_last[1], cap_data[1], exp_word(64, 6));
            end
        end
    endtask

    task automatic test_flush_exact();
        apply_reset();
        for (int b = 0; b < 63; b++) do_beat(1'b1, 1'b0);
        do_beat(1'b1, 1'b1);
        settle();
        checks++;
        if (cap_data.size() != 7) begin
            failures++;
            $display("FAIL exact_count words=%0d required=7", cap_data.size());
        end
        for (int k = 0; k < 7 && k < cap_data.size(); k++) begin
            checks++;
            if (cap_data[k] !== exp_word(k * 64, 64) || cap_last[k] !== (k == 6)) begin
                failures++;
                $display("FAIL exact_word%0d last=%0b required=%0b", k, cap_last[k], (k == 6));
            end
        end
        checks++;
        if (in_ready !== 1'b1 || word_cnt !== 16'd7) begin
            failures++;
            $display("FAIL exact_idle in_ready=%0b cnt=%0d required 1/7", in_ready, word_cnt);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        for (int b = 0; b < 10; b++) do_beat(1'b1, 1'b0);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = make_beat(gb);
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp_word(0, 64)) begin
                failures++;
                $display("FAIL bp_hold valid=%0b in_ready=%0b data=%h", out_valid, in_ready, out_data);
            end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int b = 0; b < 9; b++) do_beat(1'b1, 1'b0);
        do_beat(1'b0, 1'b1);
        settle();
        checks++;
        if (cap_data.size() != 3) begin
            failures++;
            $display("FAIL bp_count words=%0d required=3", cap_data.size());
        end else begin
            checks++;
            if (cap_data[0] !== exp_word(0, 64) || cap_data[1] !== exp_word(64, 64) ||
                cap_data[2] !== exp_word(128, 5) || cap_last[2] !== 1'b1) begin
                failures++;
                $display("FAIL bp_words data1=%h data2=%h last2=%0b", cap_data[1], cap_data[2], cap_last[2]);
            end
        end
        checks++;
        if (word_cnt !== 16'd3) begin
            failures++;
            $display("FAIL bp_cnt got=%0d required=3", word_cnt);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        for (int b = 0; b < 4; b++) do_beat(1'b1, 1'b0);
        stall = 1'b1;
        in_valid = 1'b1; in_data = make_beat(gb);
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_ready got=%0b required=0", in_ready);
            end
        end
        @(posedge clk);
        #1 stall = 1'b0;
        for (int b = 0; b < 6; b++) do_beat(1'b1, 1'b0);
        do_beat(1'b0, 1'b1);
        settle();
        checks++;
        if (cap_data.size() != 2) begin
            failures++;
            $display("FAIL stall_count words=%0d required=2", cap_data.size());
        end else begin
            checks++;
            if (cap_data[0] !== exp_word(0, 64) || cap_data[1] !== exp_word(64, 6) || cap_last[1] !== 1'b1) begin
                failures++;
                $display("FAIL stall_words data0=%h data1=%h", cap_data[0], cap_data[1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int b = 0; b < 3; b++) do_beat(1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 || word_cnt !== 16'd0) begin
            failures++;
            $display("FAIL midreset_async valid=%0b last=%0b cnt=%0d data=%h required all 0", out_valid, out_last, word_cnt, out_data);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        cap_data.delete(); cap_last.delete(); cap_keep.delete();
        gb = 0;
        for (int b = 0; b < 10; b++) do_beat(1'b1, 1'b0);
        do_beat(1'b0, 1'b1);
        settle();
        checks++;
        if (cap_data.size() != 2) begin
            failures++;
            $display("FAIL midreset_count words=%0d required=2", cap_data.size());
        end else begin
            checks++;
            if (cap_data[0] !== exp_word(0, 64) || cap_data[1] !== exp_word(64, 6) || cap_last[1] !== 1'b1) begin
                failures++;
                $display("FAIL midreset_words data0=%h required=%h", cap_data[0], exp_word(0, 64));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; stall = 1'b0;
        out_ready = 1'b1; in_data = '0;
        test_reset();
        test_stream();
        test_flush_alone();
        test_flush_with_beat();
        test_flush_exact();
        test_backpressure();
        test_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ofm_packer.md
OFM_PACKER -- requirements
Module: ofm_packer

Interface
REQ-001 Parameter IN_WIDTH, default 56: input beat width in bits; SHALL be a multiple of 8 and less than or equal to OUT_WIDTH.
REQ-002 Parameter OUT_WIDTH, default 512: output word width in bits; SHALL be a multiple of 8. Derived values: IN_BYTES=IN_WIDTH/8, OUT_BYTES=OUT_WIDTH/8.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_data  input  IN_WIDTH  beat to pack; byte 0 is bits [7:0].
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  packer accepts a beat this cycle.
REQ-008 flush  input  1  request to emit the partial word; it is accepted under the same condition as a beat.
REQ-009 stall  input  1  freeze; while it is high, no input is accepted.
REQ-010 out_data  output  OUT_WIDTH  packed word.
REQ-011 out_valid  output  1  out_data is valid.
REQ-012 out_ready  input  1  downstream accepts out_data.
REQ-013 out_last  output  1  the current word was produced by a flush.
REQ-014 word_cnt  output  16  count of words emitted; wraps modulo 2^16.

Function
REQ-015 in_ready SHALL equal !stall && !flush_pending && (!out_valid || out_ready), computed combinationally.
REQ-016 A beat handshake occurs when in_valid && in_ready; the beat's bytes SHALL be written in order at accumulator byte positions fill .. fill+IN_BYTES-1.
REQ-017 Packing SHALL be continuous across word boundaries: bytes spilling past OUT_BYTES go to positions 0.. of the next word, and no gaps are allowed.
REQ-018 fill (0..OUT_BYTES-1) SHALL advance by IN_BYTES per handshake, modulo OUT_BYTES.
REQ-019 When a handshake makes fill+IN_BYTES >= OUT_BYTES, the completed word SHALL appear on out_data with out_valid=1 and out_last=0 in the next cycle; latency is 1 cycle.
REQ-020 out_data, out_valid and out_last SHALL be held stable while out_valid && !out_ready; word_cnt SHALL increment on each out_valid && out_ready.
REQ-021 A flush is accepted when flush && in_ready. If the same cycle also has a beat handshake, the beat SHALL be packed before the flush is applied.
REQ-022 Flush when the post-beat fill is greater than 0 and no word completes: the partial word SHALL be emitted next cycle, unused bytes zero, out_last=1, and fill SHALL reset to 0.
REQ-023 Flush when the same beat completes a word and leftover bytes remain (>0): the full word is emitted first with out_last=0, and flush_pending SHALL be set.
- The leftover word is then emitted zero-padded with out_last=1 once the first word is accepted.
- flush_pending SHALL clear on acceptance of that leftover word.
REQ-024 Flush when the resulting fill is 0, and no full word completes with it: no word SHALL be emitted and out_last is not asserted.
- If a full word completes with 0 leftover, that word SHALL carry out_last=1.
REQ-025 A beat presented while in_ready=0 SHALL NOT be consumed, and in_valid and in_data are expected to hold until accepted.
REQ-026 Internal states: ACCUM (filling), HOLD (out_valid waiting on out_ready) and FLUSH_PEND (leftover awaiting emission).
- Transitions follow REQ-019..REQ-024.
- ACCUM and HOLD may coexist with a new beat accepted in the same cycle as out_ready.

Reset
REQ-027 rst_n low SHALL asynchronously clear the following to 0: out_valid, out_last, out_data, fill, flush_pending, word_cnt and the accumulator.
REQ-028 A reset mid-word SHALL discard all accumulated bytes, with no partial emission; in_ready SHALL be 1 after reset release if stall=0.

Configuration
REQ-029 Macro OFM_PACKER_KEEP_EN, when defined, SHALL add output out_keep[OUT_BYTES-1:0].
- out_keep SHALL have bit i=1 for each valid byte i of the current word: all ones for full words, and the low fill bits for flushed partial words.
- out_keep SHALL be registered alongside out_data and reset to 0.
REQ-030 Without OFM_PACKER_KEEP_EN, the out_keep port and logic SHALL be absent; the word contents are unchanged, with padding still zero.

Verification
REQ-031 Defaults, out_ready=1, 64 beats with byte value = global byte index mod 256 -> 7 words with consecutive bytes; fill=0 at the end; word_cnt=7; every out_last=0.
REQ-032 10 beats then flush alone -> word0 = bytes 0..63; word1 = bytes 64..69, rest zero, out_last=1, out_keep=0x3F when KEEP_EN is defined.
REQ-033 9 beats, then a 10th beat with flush in the same cycle:
- Expected: word0 with out_last=0, then the leftover 6-byte word with out_last=1.
- in_ready SHALL stay 0 until the second word is accepted.
REQ-034 out_ready=0 for 5 cycles with a word pending -> out_data stable and in_ready=0; no beat is lost after out_ready rises.
REQ-035 stall=1 during a burst -> no handshakes occur and fill is unchanged; packing resumes byte-exact after stall drops.
REQ-036 rst_n pulsed low after 3 beats -> outputs are 0 immediately; the next 10 beats produce word0 starting at the first post-reset byte.
